bfm_ahb_arbiter: RTL and testbench

Multi-master AHB arbiter for the BFM test environment. It shares one AHB slave segment, such as the BFM AHB slave memory model, among up to 8 BFM masters. It issues one-hot grants, tracks the address-phase owner (HMASTER) and the data-phase owner (HMASTER_D) for the external address/data muxes, and protects fixed-length bursts and locked sequences from re-arbitration. It does no data muxing itself.

---
 rtl/bfm_ahb_arbiter.sv | 100 ++++++++++
 tb/tb_bfm_ahb_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bfm_ahb_arbiter.sv
// Multi-master AHB arbiter: one-hot grant, address/data-phase owner tracking, burst and lock protection.
// Optional build macro ARB_FIXED_PRIO_EN selects fixed-priority arbitration instead of round-robin.
module bfm_ahb_arbiter #(
    parameter int NMASTER   = 4,
    parameter int DEFMASTER = 0
) (
    input  logic               HCLK,
    input  logic               HRESETN,
    input  logic [NMASTER-1:0] HBUSREQ,
    input  logic [NMASTER-1:0] HLOCK,
    input  logic [1:0]         HTRANS,
    input  logic [2:0]         HBURST,
    input  logic               HREADY,
    output logic [NMASTER-1:0] HGRANT,
    output logic [3:0]         HMASTER,
    output logic [3:0]         HMASTER_D,
    output logic               HMASTLOCK
);
    localparam int IW = (NMASTER > 1) ? $clog2(NMASTER) : 1;
    localparam logic [IW-1:0]      DEF_IDX = IW'(DEFMASTER);
    localparam logic [NMASTER-1:0] DEF_OH  = NMASTER'(1) << DEFMASTER;

    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    logic [3:0]         beat_cnt, cnt_nxt;
    logic [IW-1:0]      gidx, sel;
    logic [NMASTER-1:0] sel_oh;
    logic               lock_hold, arb_pt;

    // Remaining beats of a fixed-length burst after this edge.
    always_comb begin
        cnt_nxt = beat_cnt;
        if (HTRANS == TR_NONSEQ) begin
            case (HBURST)
                3'b010, 3'b011: cnt_nxt = 4'd3;
                3'b100, 3'b101: cnt_nxt = 4'd7;
                3'b110, 3'b111: cnt_nxt = 4'd15;
                default:        cnt_nxt = 4'd0;
            endcase
        end else if (HTRANS == TR_SEQ && beat_cnt != 4'd0) begin
            cnt_nxt = beat_cnt - 4'd1;
        end
    end

    assign lock_hold = HLOCK[gidx] & HBUSREQ[gidx];
    assign arb_pt    = HREADY && (cnt_nxt == 4'd0) && !lock_hold;

`ifdef ARB_FIXED_PRIO_EN
    // Descending scan so the lowest requesting index is the last write.
    always_comb begin
        sel = DEF_IDX;
        for (int i = NMASTER - 1; i >= 0; i--) begin
            if (HBUSREQ[IW'(i)]) sel = IW'(i);
        end
    end
`else
    // The current grant index doubles as the round-robin pointer.
    always_comb begin
        logic found;
        int   idx;
        sel   = DEF_IDX;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NMASTER; k++) begin
            idx = int'(gidx) + k;
            if (idx >= NMASTER) idx = idx - NMASTER;
            if (!found && HBUSREQ[IW'(idx)]) begin
                sel   = IW'(idx);
                found = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        sel_oh      = '0;
        sel_oh[sel] = 1'b1;
    end

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            beat_cnt  <= 4'd0;
            gidx      <= DEF_IDX;
            HGRANT    <= DEF_OH;
            HMASTER   <= 4'(DEF_IDX);
            HMASTER_D <= 4'(DEF_IDX);
            HMASTLOCK <= 1'b0;
        end else if (HREADY) begin
            beat_cnt  <= cnt_nxt;
            HMASTER   <= 4'(gidx);
            HMASTER_D <= HMASTER;
            HMASTLOCK <= HLOCK[gidx];
            if (arb_pt) begin
                gidx   <= sel;
                HGRANT <= sel_oh;
            end
        end
    end
endmodule

// File: tb/tb_bfm_ahb_arbiter.sv
// Self-checking bench for bfm_ahb_arbiter: directed scenarios plus randomized traffic vs a behavioural model.
module tb_bfm_ahb_arbiter;
    localparam int NM = 4;
    localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;

    logic          HCLK = 1'b0;
    logic          HRESETN;
    logic [NM-1:0] HBUSREQ, HLOCK;
    logic [1:0]    HTRANS;
    logic [2:0]    HBURST;
    logic          HREADY;
    logic [NM-1:0] HGRANT;
    logic [3:0]    HMASTER, HMASTER_D;
    logic          HMASTLOCK;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: plain integers, burst tracked as beats remaining.
    int m_gnt, m_mst, m_mstd, m_lock, m_beats;

    bfm_ahb_arbiter #(.NMASTER(NM), .DEFMASTER(0)) dut (
        .HCLK(HCLK), .HRESETN(HRESETN), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
        .HTRANS(HTRANS), .HBURST(HBURST), .HREADY(HREADY), .HGRANT(HGRANT),
        .HMASTER(HMASTER), .HMASTER_D(HMASTER_D), .HMASTLOCK(HMASTLOCK)
    );

    always #5 HCLK = ~HCLK;

    function automatic int burst_beats(input logic [2:0] b);
        case (int'(b) / 2)
            1: return 4;
            2: return 8;
            3: return 16;
            default: return 1;
        endcase
    endfunction

    function automatic int pick(input int g, input logic [NM-1:0] req);
`ifdef ARB_FIXED_PRIO_EN
        for (int i = 0; i < NM; i++) if (req[i]) return i;
`else
        for (int k = 1; k <= NM; k++) if (req[(g + k) % NM]) return (g + k) % NM;
`endif
        return 0;
    endfunction

    task automatic model_reset();
        m_gnt = 0; m_mst = 0; m_mstd = 0; m_lock = 0; m_beats = 0;
    endtask

    task automatic step();
        @(posedge HCLK);
        if (HRESETN && HREADY) begin
            if (HTRANS == NONSEQ) m_beats = burst_beats(HBURST) - 1;
            else if (HTRANS == SEQ && m_beats > 0) m_beats--;
            m_mstd = m_mst;
            m_mst  = m_gnt;
            m_lock = HLOCK[m_gnt];
            if (m_beats == 0 && !(HLOCK[m_gnt] && HBUSREQ[m_gnt])) m_gnt = pick(m_gnt, HBUSREQ);
        end
        #1;
    endtask

    task automatic do_reset();
        HRESETN = 1'b0;
        HBUSREQ = '0; HLOCK = '0; HTRANS = IDLE; HBURST = 3'b000; HREADY = 1'b1;
        model_reset();
        repeat (2) @(negedge HCLK);
        HRESETN = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if ({HGRANT, HMASTER, HMASTER_D, HMASTLOCK} !== {4'b0001, 4'd0, 4'd0, 1'b0})
            $display("FAIL reset_values got %b/%0d/%0d/%b exp 0001/0/0/0", HGRANT, HMASTER, HMASTER_D, HMASTLOCK);
        else n_pass++;
        step();
        n_chk++;
        if ({HGRANT, HMASTER, HMASTER_D, HMASTLOCK} !== {4'b0001, 4'd0, 4'd0, 1'b0})
            $display("FAIL reset_idle_park got %b/%0d/%0d/%b exp 0001/0/0/0", HGRANT, HMASTER, HMASTER_D, HMASTLOCK);
        else n_pass++;
    endtask

`ifndef ARB_FIXED_PRIO_EN
    task automatic test_round_robin();
        int eg[5] = '{1, 2, 3, 0, 1};
        int em[5] = '{0, 1, 2, 3, 0};
        int ed[5] = '{0, 0, 1, 2, 3};
        do_reset();
        HBUSREQ = 4'b1111; HTRANS = NONSEQ; HBURST = 3'b000;
        for (int i = 0; i < 5; i++) begin
            step();
            n_chk++;
            if (HGRANT !== 4'(1 << eg[i]) || HMASTER !== 4'(em[i]) || HMASTER_D !== 4'(ed[i]))
                $display("FAIL rr_order[%0d] got %b/%0d/%0d exp %b/%0d/%0d", i, HGRANT, HMASTER, HMASTER_D,
                         4'(1 << eg[i]), em[i], ed[i]);
            else n_pass++;
        end
    endtask
`else
    task automatic test_fixed_prio();
        do_reset();
        HBUSREQ = 4'b1010; HTRANS = NONSEQ; HBURST = 3'b000;
        for (int i = 0; i < 6; i++) begin
            step();
            n_chk++;
            if (HGRANT !== 4'b0010) $display("FAIL fixed_prio[%0d] got %b exp 0010", i, HGRANT);
            else n_pass++;
        end
    endtask
`endif

    task automatic test_burst();
        for (int stall = 0; stall < 2; stall++) begin
            int nr, held;
            do_reset();
            HBUSREQ = 4'b0010;
            step();
            step();
            n_chk++;
            if (HGRANT !== 4'b0010 || HMASTER !== 4'd1)
                $display("FAIL burst_setup got %b/%0d exp 0010/1", HGRANT, HMASTER);
            else n_pass++;
            HTRANS = NONSEQ; HBURST = 3'b101; HBUSREQ = 4'b0100;
            nr = 0; held = 0;
            for (int e = 0; e < 8 + 2 * stall; e++) begin
                logic [3:0] want;
                HREADY = !(stall == 1 && (e == 2 || e == 4));
                step();
                if (HREADY) nr++;
                want = (nr == 8) ? 4'b0100 : 4'b0010;
                n_chk++;
                if (HGRANT !== want) $display("FAIL burst_hold s%0d e%0d got %b exp %b", stall, e, HGRANT, want);
                else n_pass++;
                if (HGRANT == 4'b0010) held++;
                HTRANS = SEQ;
            end
            HREADY = 1'b1;
            n_chk++;
            if (held !== 7 + 2 * stall) $display("FAIL burst_len s%0d got %0d exp %0d", stall, held, 7 + 2 * stall);
            else n_pass++;
        end
    endtask

    task automatic test_lock();
        do_reset();
        HBUSREQ = 4'b1000; HLOCK = 4'b1000;
        step();
        HBUSREQ = 4'b1011; HTRANS = NONSEQ; HBURST = 3'b000;
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            n_chk++;
            if (HGRANT !== 4'b1000 || HMASTLOCK !== 1'b1 || HMASTER !== 4'd3)
                $display("FAIL lock_hold[%0d] got %b/%b/%0d exp 1000/1/3", i, HGRANT, HMASTLOCK, HMASTER);
            else n_pass++;
        end
        HBUSREQ = 4'b0011; HLOCK = 4'b0000;
        step();
        n_chk++;
        if (HGRANT !== 4'b0001) $display("FAIL lock_release got %b exp 0001", HGRANT);
        else n_pass++;
    endtask

    task automatic test_park_incr();
        logic [3:0] want;
        do_reset();
        HBUSREQ = 4'b0010;
        step();
        HBUSREQ = 4'b0000;
        step();
        n_chk++;
        if (HGRANT !== 4'b0001) $display("FAIL park got %b exp 0001", HGRANT);
        else n_pass++;
        HBUSREQ = 4'b0001;
        step();
        step();
        n_chk++;
        if (HGRANT !== 4'b0001 || HMASTER !== 4'd0) $display("FAIL incr_owner got %b/%0d exp 0001/0", HGRANT, HMASTER);
        else n_pass++;
        HTRANS = NONSEQ; HBURST = 3'b001;
        step();
        HTRANS = SEQ; HBUSREQ = 4'b0101;
        step();
`ifdef ARB_FIXED_PRIO_EN
        want = 4'b0001;
`else
        want = 4'b0100;
`endif
        n_chk++;
        if (HGRANT !== want) $display("FAIL incr_preempt got %b exp %b", HGRANT, want);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        HBUSREQ = 4'b0100;
        step();
        step();
        HTRANS = NONSEQ; HBURST = 3'b111;
        step();
        HTRANS = SEQ;
        step();
        step();
        n_chk++;
        if (HGRANT !== 4'b0100 || HMASTER !== 4'd2) $display("FAIL midburst_pre got %b/%0d exp 0100/2", HGRANT, HMASTER);
        else n_pass++;
        #2 HRESETN = 1'b0;
        #1;
        n_chk++;
        if ({HGRANT, HMASTER, HMASTER_D, HMASTLOCK} !== {4'b0001, 4'd0, 4'd0, 1'b0})
            $display("FAIL async_reset got %b/%0d/%0d/%b exp 0001/0/0/0", HGRANT, HMASTER, HMASTER_D, HMASTLOCK);
        else n_pass++;
        model_reset();
        @(negedge HCLK);
        HRESETN = 1'b1;
        HBUSREQ = 4'b1000;
        step();
        n_chk++;
        if (HGRANT !== 4'b1000) $display("FAIL reset_discards_burst got %b exp 1000", HGRANT);
        else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            HBUSREQ = 4'($urandom);
            HLOCK   = 4'($urandom) & 4'($urandom);
            HTRANS  = ($urandom_range(0, 1) == 1) ? SEQ : 2'($urandom);
            HBURST  = 3'($urandom);
            HREADY  = ($urandom_range(0, 4) != 0);
            step();
            n_chk++;
            if ({HGRANT, HMASTER, HMASTER_D, HMASTLOCK} !== {4'(1 << m_gnt), 4'(m_mst), 4'(m_mstd), 1'(m_lock)} ||
                !$onehot(HGRANT))
                $display("FAIL random[%0d] got %b/%0d/%0d/%b exp %b/%0d/%0d/%0d", i, HGRANT, HMASTER, HMASTER_D,
                         HMASTLOCK, 4'(1 << m_gnt), m_mst, m_mstd, m_lock);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
`ifndef ARB_FIXED_PRIO_EN
        test_round_robin();
`else
        test_fixed_prio();
`endif
        test_burst();
        test_lock();
        test_park_incr();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
